padmux_ctrl: RTL and testbench

- Parametrised pad multiplexer and pad controller for the zerosoc padring.
- Replaces fixed per-side pin assignment with a runtime-programmable per-pad function select: GPIO or one of NFUNC-1 peripheral alternates.
- Provides per-pad config bits, input synchronisers and a write-lock.
- Sits between the core (GPIO, UART, other peripherals) and the padring din/dout/oen/ie/cfg buses. Programmed through a simple valid/ready register port.

---
 rtl/padmux_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_padmux_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/padmux_ctrl.sv
// padmux_ctrl: runtime-programmable pad multiplexer / pad controller.
//   Each pad gets a 32-bit config register (func, ie_dis, filt_en, cfg, lock)
//   programmed through a valid/ready register port with a decoupled read
//   response. Output path is registered (1 cycle); input path goes through
//   SYNC_STAGES flops and is routed only to the selected function.
// Optional build macro: PADMUX_FILTER_EN adds a per-pad stability filter
//   after the synchroniser, enabled per pad by filt_en.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   reg_valid/ready/we/addr/wdata   register request
//   reg_rvalid/rready/rdata, reg_err  read response, out-of-range pulse
//   gpio_o_i/gpio_en_i/gpio_i_o  GPIO side (function 0)
//   alt_out_i/alt_oe_i/alt_in_o  alternates, index f*NPADS+p = func f+1
//   pad_din/dout/oen/ie/cfg      padring side
module padmux_ctrl #(
  parameter int NPADS       = 36,
  parameter int NFUNC       = 4,
  parameter int CFGW        = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         reg_valid_i,
  output logic                         reg_ready_o,
  input  logic                         reg_we_i,
  input  logic [$clog2(NPADS)-1:0]     reg_addr_i,
  input  logic [31:0]                  reg_wdata_i,
  output logic                         reg_rvalid_o,
  input  logic                         reg_rready_i,
  output logic [31:0]                  reg_rdata_o,
  output logic                         reg_err_o,
  input  logic [NPADS-1:0]             gpio_o_i,
  input  logic [NPADS-1:0]             gpio_en_i,
  output logic [NPADS-1:0]             gpio_i_o,
  input  logic [(NFUNC-1)*NPADS-1:0]   alt_out_i,
  input  logic [(NFUNC-1)*NPADS-1:0]   alt_oe_i,
  output logic [(NFUNC-1)*NPADS-1:0]   alt_in_o,
  input  logic [NPADS-1:0]             pad_din_i,
  output logic [NPADS-1:0]             pad_dout_o,
  output logic [NPADS-1:0]             pad_oen_o,
  output logic [NPADS-1:0]             pad_ie_o,
  output logic [NPADS*CFGW-1:0]        pad_cfg_o
);
  localparam int FS = $clog2(NFUNC);

  typedef struct packed {
    logic            lock;
    logic [CFGW-1:0] cfg;
    logic            filt_en;
    logic            ie_dis;
    logic [FS-1:0]   func;
  } pad_reg_t;

  pad_reg_t         regs_q [NPADS];
  logic             accept, in_range;
  logic [31:0]      rd_word;
  logic [NPADS-1:0] sync_q [SYNC_STAGES];
  logic [NPADS-1:0] sync_out, in_val;
  logic [NPADS-1:0] dsel, osel;
  logic             unused_wdata;

  assign unused_wdata = ^reg_wdata_i;

  // Register port
  assign reg_ready_o = ~reg_rvalid_o | reg_rready_i;
  assign accept      = reg_valid_i & reg_ready_o;
  assign in_range    = 32'(reg_addr_i) < 32'(NPADS);

  always_comb begin
    rd_word = '0;
    if (in_range) begin
      rd_word[FS-1:0]      = regs_q[reg_addr_i].func;
      rd_word[8]           = regs_q[reg_addr_i].ie_dis;
      rd_word[9]           = regs_q[reg_addr_i].filt_en;
      rd_word[16+:CFGW]    = regs_q[reg_addr_i].cfg;
      rd_word[31]          = regs_q[reg_addr_i].lock;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int p = 0; p < NPADS; p++) regs_q[p] <= '0;
    end else if (accept && reg_we_i && in_range && !regs_q[reg_addr_i].lock) begin
      regs_q[reg_addr_i] <= '{lock:    reg_wdata_i[31],
                              cfg:     reg_wdata_i[16+:CFGW],
                              filt_en: reg_wdata_i[9],
                              ie_dis:  reg_wdata_i[8],
                              func:    reg_wdata_i[FS-1:0]};
    end
  end

  // A write accepted while a response is completing falls into the rready
  // branch and retires the response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      reg_rvalid_o <= 1'b0;
      reg_rdata_o  <= '0;
      reg_err_o    <= 1'b0;
    end else begin
      reg_err_o <= accept & ~in_range;
      if (accept && !reg_we_i) begin
        reg_rvalid_o <= 1'b1;
        reg_rdata_o  <= rd_word;
      end else if (reg_rready_i) begin
        reg_rvalid_o <= 1'b0;
      end
    end
  end

  // Input synchroniser
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= pad_din_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end
  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef PADMUX_FILTER_EN
  // Filtered value flips on the (2^FILT_W-1)th consecutive differing cycle;
  // any agreeing cycle restarts the count.
  localparam logic [FILT_W-1:0] FMAX = FILT_W'((1 << FILT_W) - 2);
  logic [NPADS-1:0]  filt_q;
  logic [FILT_W-1:0] fcnt_q [NPADS];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      filt_q <= '0;
      for (int p = 0; p < NPADS; p++) fcnt_q[p] <= '0;
    end else begin
      for (int p = 0; p < NPADS; p++) begin
        if (sync_out[p] != filt_q[p]) begin
          if (fcnt_q[p] == FMAX) begin
            filt_q[p] <= sync_out[p];
            fcnt_q[p] <= '0;
          end else begin
            fcnt_q[p] <= fcnt_q[p] + 1'b1;
          end
        end else begin
          fcnt_q[p] <= '0;
        end
      end
    end
  end

  always_comb begin
    in_val = sync_out;
    for (int p = 0; p < NPADS; p++)
      if (regs_q[p].filt_en) in_val[p] = filt_q[p];
  end
`else
  assign in_val = sync_out;
`endif

  // Per-pad function mux
  for (genvar p = 0; p < NPADS; p++) begin : g_pad
    logic [FS-1:0]    efunc;
    logic [NFUNC-1:0] dv, ov, iv;

    // Unimplemented function codes fall back to GPIO.
    assign efunc = (32'(regs_q[p].func) < 32'(NFUNC)) ? regs_q[p].func : '0;

    assign dv[0]       = gpio_o_i[p];
    assign ov[0]       = gpio_en_i[p];
    assign gpio_i_o[p] = iv[0];
    for (genvar f = 1; f < NFUNC; f++) begin : g_alt
      assign dv[f]                   = alt_out_i[(f-1)*NPADS+p];
      assign ov[f]                   = alt_oe_i[(f-1)*NPADS+p];
      assign alt_in_o[(f-1)*NPADS+p] = iv[f];
    end

    always_comb begin
      iv        = '0;
      iv[efunc] = in_val[p];
    end

    assign dsel[p] = dv[efunc];
    assign osel[p] = ov[efunc];
    assign pad_ie_o[p] = pad_oen_o[p] & ~regs_q[p].ie_dis;
    assign pad_cfg_o[p*CFGW +: CFGW] = regs_q[p].cfg;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pad_dout_o <= '0;
      pad_oen_o  <= '1;
    end else begin
      pad_dout_o <= dsel;
      pad_oen_o  <= ~osel;
    end
  end

endmodule

// File: tb/tb_padmux_ctrl.sv
// Directed self-checking bench for padmux_ctrl (NPADS=36, NFUNC=4, CFGW=8).
module tb_padmux_ctrl;
  localparam int NP = 36;
  localparam int NF = 4;
  localparam int CW = 8;
  localparam int NA = (NF-1)*NP;

  logic          clk = 1'b0;
  logic          rst;
  logic          reg_valid, reg_ready, reg_we, reg_rvalid, reg_rready, reg_err;
  logic [5:0]    reg_addr;
  logic [31:0]   reg_wdata, reg_rdata;
  logic [NP-1:0] gpio_o, gpio_en, gpio_i, pad_din, pad_dout, pad_oen, pad_ie;
  logic [NA-1:0] alt_out, alt_oe, alt_in;
  logic [NP*CW-1:0] pad_cfg;

  int checks = 0;
  int failures = 0;

  padmux_ctrl dut (
    .clk_i(clk), .rst_i(rst),
    .reg_valid_i(reg_valid), .reg_ready_o(reg_ready), .reg_we_i(reg_we),
    .reg_addr_i(reg_addr), .reg_wdata_i(reg_wdata),
    .reg_rvalid_o(reg_rvalid), .reg_rready_i(reg_rready),
    .reg_rdata_o(reg_rdata), .reg_err_o(reg_err),
    .gpio_o_i(gpio_o), .gpio_en_i(gpio_en), .gpio_i_o(gpio_i),
    .alt_out_i(alt_out), .alt_oe_i(alt_oe), .alt_in_o(alt_in),
    .pad_din_i(pad_din), .pad_dout_o(pad_dout), .pad_oen_o(pad_oen),
    .pad_ie_o(pad_ie), .pad_cfg_o(pad_cfg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    reg_valid = 1'b1; reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    @(posedge clk); #1;
    reg_valid = 1'b0; reg_we = 1'b0;
  endtask

  // Read with reg_rready high: response must appear right after acceptance
  // and retire on the following edge.
  task automatic rd_chk(input string tag, input logic [5:0] a, input logic [31:0] exp);
    reg_valid = 1'b1; reg_we = 1'b0; reg_addr = a;
    @(posedge clk); #1;
    reg_valid = 1'b0;
    chk({tag, "_rv"}, reg_rvalid, 1);
    chk(tag, reg_rdata, exp);
    cyc(1);
    chk({tag, "_rv0"}, reg_rvalid, 0);
  endtask

  initial begin
    rst = 1'b1; reg_valid = 0; reg_we = 0; reg_addr = 0; reg_wdata = 0;
    reg_rready = 1'b1; gpio_o = 0; gpio_en = 0; alt_out = 0; alt_oe = 0;
    pad_din = 0;
    cyc(3);
    rst = 1'b0;

    // Reset state
    chk("rst_oen",  pad_oen, {NP{1'b1}});
    chk("rst_ie",   pad_ie, {NP{1'b1}});
    chk("rst_dout", pad_dout, 0);
    chk("rst_rv",   reg_rvalid, 0);
    chk("rst_rdy",  reg_ready, 1);
    chk("rst_err",  reg_err, 0);
    chk("rst_cfg",  |pad_cfg, 0);
    chk("rst_gin",  gpio_i, 0);
    rd_chk("rd3", 3, 32'h0);

    // Pad 5 -> alternate 1, pad 6 stays GPIO
    alt_out[5] = 1'b1; alt_oe[5] = 1'b1;
    gpio_o[6] = 1'b1; gpio_en[6] = 1'b1;
    wr(5, 32'h00AB_0001);
    cyc(1);
    chk("alt_dout5", pad_dout[5], 1);
    chk("alt_oen5",  pad_oen[5], 0);
    chk("alt_ie5",   pad_ie[5], 0);
    chk("cfg5",      pad_cfg[47:40], 8'hAB);
    chk("gpio_dout6", pad_dout[6], 1);
    chk("gpio_oen6",  pad_oen[6], 0);
    alt_out[5] = 1'b0; gpio_o[5] = 1'b1; gpio_en[5] = 1'b0;
    cyc(1);
    chk("alt_ignore_gpio5", pad_dout[5], 0);
    chk("alt_oen5b",        pad_oen[5], 0);
    rd_chk("rd5", 5, 32'h00AB_0001);

    // Input synchroniser latency and routing on pad 7
    pad_din[7] = 1'b1;
    cyc(1);
    chk("sync7_1cyc", gpio_i[7], 0);
    cyc(1);
    chk("sync7_2cyc", gpio_i[7], 1);
    chk("sync7_alt0", {alt_in[2*NP+7], alt_in[NP+7], alt_in[7]}, 0);
    wr(7, 32'h0000_0002);
    chk("f2_alt_in", alt_in[NP+7], 1);
    chk("f2_gpio_i", gpio_i[7], 0);
    chk("f2_other",  {alt_in[2*NP+7], alt_in[7]}, 0);

    // ie_dis on a GPIO pad with output disabled
    wr(8, 32'h0000_0100);
    chk("iedis_ie8",  pad_ie[8], 0);
    chk("iedis_oen8", pad_oen[8], 1);

    // Lock
    wr(2, 32'h8000_0000);
    wr(2, 32'h0000_0003);
    chk("lock_noerr", reg_err, 0);
    rd_chk("lock_rd2", 2, 32'h8000_0000);
    wr(9, 32'hFFFF_FFFF);
    rd_chk("rd9_mask", 9, 32'h80FF_0303);

    // Stalled read response, then back-to-back out-of-range read
    reg_rready = 1'b0;
    reg_valid = 1'b1; reg_we = 1'b0; reg_addr = 5;
    @(posedge clk); #1;
    reg_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_rdy", reg_ready, 0);
      chk("stall_rv",  reg_rvalid, 1);
      chk("stall_rd",  reg_rdata, 32'h00AB_0001);
      cyc(1);
    end
    reg_rready = 1'b1;
    reg_valid = 1'b1; reg_addr = 40;
    #1;
    chk("b2b_rdy", reg_ready, 1);
    @(posedge clk); #1;
    reg_valid = 1'b0;
    chk("oor_rv",  reg_rvalid, 1);
    chk("oor_rd",  reg_rdata, 0);
    chk("oor_err", reg_err, 1);
    cyc(1);
    chk("oor_err_pulse", reg_err, 0);
    chk("oor_rv0", reg_rvalid, 0);
    wr(40, 32'hFFFF_FFFF);
    chk("oorw_err", reg_err, 1);
    cyc(1);
    chk("oorw_err0", reg_err, 0);

`ifdef PADMUX_FILTER_EN
    // Filter on pad 0: 10-cycle pulse rejected, long high accepted at 2+15
    wr(0, 32'h0000_0200);
    begin
      logic seen;
      seen = 1'b0;
      pad_din[0] = 1'b1;
      for (int i = 0; i < 10; i++) begin cyc(1); seen = seen | gpio_i[0]; end
      pad_din[0] = 1'b0;
      for (int i = 0; i < 20; i++) begin cyc(1); seen = seen | gpio_i[0]; end
      chk("filt_short", seen, 0);
    end
    pad_din[0] = 1'b1;
    cyc(16);
    chk("filt_16", gpio_i[0], 0);
    cyc(1);
    chk("filt_17", gpio_i[0], 1);
    cyc(3);
    pad_din[0] = 1'b0;
    cyc(2);
`else
    // filt_en has no effect without the filter: plain 2-cycle latency
    wr(0, 32'h0000_0200);
    rd_chk("filt_rb", 0, 32'h0000_0200);
    pad_din[0] = 1'b1;
    cyc(2);
    chk("nofilt_rise", gpio_i[0], 1);
    pad_din[0] = 1'b0;
    cyc(2);
    chk("nofilt_fall", gpio_i[0], 0);
`endif

    // Reset in the middle of a pending read response
    reg_rready = 1'b0;
    reg_valid = 1'b1; reg_we = 1'b0; reg_addr = 9;
    @(posedge clk); #1;
    reg_valid = 1'b0;
    chk("mid_rv", reg_rvalid, 1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("mid_rst_rv", reg_rvalid, 0);
    chk("mid_rst_oen5", pad_oen[5], 1);
    reg_rready = 1'b1;
    rd_chk("rst_rd2", 2, 32'h0);
    rd_chk("rst_rd5", 5, 32'h0);
    wr(2, 32'h0000_0001);
    rd_chk("unlock_rd2", 2, 32'h0000_0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
